// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - op codes, default latencies and state type for the MD scheduler
package md_sched_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// rtl/md_sched_if.sv - EX-stage to MD scheduler signal bundle
interface md_sched_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic        id_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, mthi, mtlo, flush, id_md,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, mthi, mtlo, flush, id_md,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational mult/div datapath producing HI/LO results
module md_arith
    import md_sched_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_b_zero;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_mag_a  = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_mag_b  = i_b[31] ? (~i_b + 32'd1) : i_b;
    assign w_b_zero = (i_b == 32'd0);
    assign w_uq     = w_b_zero ? 32'd0 : (i_a / i_b);
    assign w_ur     = w_b_zero ? 32'd0 : (i_a % i_b);
    assign w_sq     = w_b_zero ? 32'd0 : (w_mag_a / w_mag_b);
    assign w_sr     = w_b_zero ? 32'd0 : (w_mag_a % w_mag_b);

    always_comb begin
        o_hi   = 32'd0;
        o_lo   = 32'd0;
        o_div0 = 1'b0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV: begin
                o_lo   = (i_a[31] ^ i_b[31]) ? (~w_sq + 32'd1) : w_sq;
                o_hi   = i_a[31] ? (~w_sr + 32'd1) : w_sr;
                o_div0 = w_b_zero;
            end
            MD_DIVU: begin
                o_lo   = w_uq;
                o_hi   = w_ur;
                o_div0 = w_b_zero;
            end
            // Undefined op codes leave HI/LO untouched, same as a zero divisor.
            default:  o_div0 = 1'b1;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multi-cycle mult/div scheduler owning HI/LO and the MD stall
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    md_sched_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]       r_op,    w_op_nxt;
    logic [31:0]      r_a,     w_a_nxt;
    logic [31:0]      r_b,     w_b_nxt;
    logic [31:0]      r_hi,    w_hi_nxt;
    logic [31:0]      r_lo,    w_lo_nxt;

    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div0;

    md_arith u_arith (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_hi   (w_res_hi),
        .o_lo   (w_res_lo),
        .o_div0 (w_div0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_op_nxt    = bus.md_op;
                    w_a_nxt     = bus.rs_val;
                    w_b_nxt     = bus.rt_val;
                    w_cnt_nxt   = is_mult_op(bus.md_op) ? MULT_LAST : DIV_LAST;
                    w_state_nxt = ST_BUSY;
                end else if (bus.mthi && !bus.flush) begin
                    w_hi_nxt = bus.rs_val;
                end else if (bus.mtlo && !bus.flush) begin
                    w_lo_nxt = bus.rs_val;
                end
            end
            ST_BUSY: begin
                // Issuing instruction already left EX, so flush cannot abort here.
                if (r_cnt == '0) begin
                    if (!w_div0) begin
                        w_hi_nxt = w_res_hi;
                        w_lo_nxt = w_res_lo;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy  = (r_state == ST_BUSY);
    assign bus.stall = bus.id_md && (bus.start || bus.busy);
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched
module tb_md_sched;
    import md_sched_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    md_sched_if bus ();

    md_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.busy && (bus.start || bus.mthi || bus.mtlo))
            $error("FAIL proto: issue while busy");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives a start in cycle t, then checks busy/stall for N cycles and HI/LO in t+N+1.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic idm, input int flush_at,
                          input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.start  = 1'b1;
        bus.id_md  = 1'b1;
        #1 chk({tag, "_stall_t"}, {31'd0, bus.stall}, 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.id_md  = idm;
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            bus.flush  = (k == flush_at);
            #1;
            chk({tag, "_busy"},  {31'd0, bus.busy},  32'd1);
            chk({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, idm});
        end
        @(negedge clk);
        bus.flush = 1'b0;
        bus.id_md = 1'b0;
        #1;
        chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_hi"},   bus.hi, eh);
        chk({tag, "_lo"},   bus.lo, el);
    endtask

    task automatic move_to(input logic to_hi, input logic [31:0] v, input logic fl);
        @(negedge clk);
        bus.rs_val = v;
        bus.mthi   = to_hi;
        bus.mtlo   = !to_hi;
        bus.flush  = fl;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.md_op  = 3'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.flush  = 1'b0;
        bus.id_md  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_hi",    bus.hi, 32'd0);
        chk("rst_lo",    bus.lo, 32'd0);
        rst_n = 1'b1;

        run_op("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 5, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 0, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_n", MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_d", MD_DIV,   32'd7, 32'hFFFF_FFFE, 10, 1'b1, 0, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ov", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 0, 32'h0000_0000, 32'h8000_0000);
        run_op("divu",  MD_DIVU,  32'd100, 32'd7, 10, 1'b1, 3, 32'h0000_0002, 32'h0000_000E);

        move_to(1'b1, 32'h11, 1'b0);
        move_to(1'b0, 32'h22, 1'b0);
        #1;
        chk("mthi", bus.hi, 32'h11);
        chk("mtlo", bus.lo, 32'h22);
        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10, 1'b1, 0, 32'h11, 32'h22);

        move_to(1'b1, 32'hDEAD, 1'b1);
        #1 chk("mthi_flush", bus.hi, 32'h11);

        @(negedge clk);
        bus.md_op  = MD_MULT;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd5;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1 chk("sflush_busy", {31'd0, bus.busy}, 32'd0);
        repeat (6) @(negedge clk);
        #1;
        chk("sflush_hi", bus.hi, 32'h11);
        chk("sflush_lo", bus.lo, 32'h22);

        @(negedge clk);
        bus.md_op  = MD_MULT;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd5;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rmid_hi",   bus.hi, 32'd0);
        chk("rmid_lo",   bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("rpost_busy", {31'd0, bus.busy}, 32'd0);
        chk("rpost_hi",   bus.hi, 32'd0);
        chk("rpost_lo",   bus.lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
